// File: rtl/tisc_alu_pkg.sv
// Shared types for the TISC pipelined ALU: opcodes, flag bit positions and
// the control FSM state encoding.
package tisc_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_SHL = 4'd2,
        OP_CMP = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_SHR = 4'd7,
        OP_ADC = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/tisc_alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// low WIDTH bits of the product presented combinationally with done_o.
module tisc_alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    // The final step is folded into product_o so the result lands on the
    // WIDTH-th edge after start rather than one later.
    assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product_o = acc_d;
    assign busy_o    = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (done_o) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tisc_alu_pipe.sv
// Handshaked TISC ALU: single-cycle logic/arithmetic plus sequential MUL,
// with a registered result and persistent {C,Z,N,V} flags.
module tisc_alu_pipe
    import tisc_alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [3:0]       flags_q, flags_d;

    logic             in_ready_int, accept, is_mul, mul_start;
    logic             mul_busy, mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic             cin;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_y;
    logic [3:0]       alu_flags, mul_flags;

    tisc_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_prod)
    );

    assign is_mul = MUL_EN && (op == OP_MUL);
    assign cin    = (op == OP_ADC) ? flags_q[FLAG_C] : 1'b0;
    assign sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff   = {1'b0, a} - {1'b0, b};

    always_comb begin
        logic c, v, upd, add_v, sub_v;
        add_v     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_v     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        alu_y     = '0;
        c         = 1'b0;
        v         = 1'b0;
        upd       = 1'b1;
        alu_flags = flags_q;
        case (op)
            OP_ADD, OP_ADC: begin alu_y = sum[WIDTH-1:0];  c = sum[WIDTH];  v = add_v; end
            OP_SUB:         begin alu_y = diff[WIDTH-1:0]; c = diff[WIDTH]; v = sub_v; end
            OP_CMP:         begin alu_y = WIDTH'(a == b);  c = diff[WIDTH]; v = sub_v; end
            OP_SHL:         begin alu_y = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
            OP_SHR:         begin alu_y = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
            OP_AND:         alu_y = a & b;
            OP_OR:          alu_y = a | b;
            OP_XOR:         alu_y = a ^ b;
            default:        upd = 1'b0;
        endcase
        if (upd) begin
            alu_flags[FLAG_C] = c;
            alu_flags[FLAG_Z] = (op == OP_CMP) ? (a == b)        : (alu_y == '0);
            alu_flags[FLAG_N] = (op == OP_CMP) ? diff[WIDTH-1]   : alu_y[WIDTH-1];
            alu_flags[FLAG_V] = v;
        end
    end

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_prod == '0);
        mul_flags[FLAG_N] = mul_prod[WIDTH-1];
    end

    assign in_ready_int = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept       = in_valid && in_ready_int;
    assign in_ready     = !rst && in_ready_int;
    assign out_valid    = (state_q == ST_HOLD);
    assign y            = y_q;
    assign flags        = flags_q;

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        flags_d   = flags_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d   = ST_BUSY;
                        mul_start = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        y_d     = alu_y;
                        flags_d = alu_flags;
                    end
                end else if (state_q == ST_HOLD && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d = ST_HOLD;
                    y_d     = mul_prod;
                    flags_d = mul_flags;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

endmodule
